if_prefetch_buffer: RTL

Instruction prefetch buffer between instruction memory and the decode stage. Fetches sequential words over a req/ack handshake, queues up to DEPTH instructions with their PCs, and presents the head to ID. Honours ID's Stall, and flushes and refetches on a Branch/Jump redirect. Decouples IF from variable-latency instruction memory.

---
 rtl/if_prefetch_buffer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/if_prefetch_buffer.sv
// Instruction prefetch queue between instruction memory and ID; one fetch in flight at a time.
// Optional same-cycle ack-to-ID bypass when the queue is empty: IF_PREFETCH_BYPASS_EN.
module if_prefetch_buffer #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                     Clk,
   input  logic                     Resetn,
   output logic                     IMemReq,
   output logic [31:0]              IMemAddr,
   input  logic                     IMemAck,
   input  logic [31:0]              IMemData,
   input  logic                     Redirect,
   input  logic [31:0]              RedirectPC,
   input  logic                     Stall,
   output logic [31:0]              Inst,
   output logic [31:0]              InstPC,
   output logic                     InstValid,
   output logic [$clog2(DEPTH):0]   Count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned DepthVal = DEPTH;
   localparam logic [AW:0] Full = DepthVal[AW:0];

   typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

   state_e        state_q, state_d;
   logic          req_q, req_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0]   count_q, count_d;

   logic [31:0]   pc_mem   [DEPTH];
   logic [31:0]   inst_mem [DEPTH];

   logic          head_valid;
   logic          ack_acc;
   logic          bypass;
   logic          push;
   logic          pop;

   assign head_valid = (count_q != '0);
   assign ack_acc    = (state_q == StReq) && IMemAck && !Redirect;

`ifdef IF_PREFETCH_BYPASS_EN
   assign bypass = ack_acc && !head_valid;
`else
   assign bypass = 1'b0;
`endif

   // A bypassed word that ID takes immediately never enters the queue.
   assign push = ack_acc && !(bypass && !Stall);
   assign pop  = head_valid && !Stall && !Redirect;

   always_comb begin
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (!push && pop) begin
         count_d = count_q - 1'b1;
      end
      if (Redirect) begin
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end
   end

   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      addr_d     = addr_q;
      fetch_pc_d = fetch_pc_q;
      unique case (state_q)
         StIdle: begin
            if (!Redirect && (count_q != Full)) begin
               state_d = StReq;
               req_d   = 1'b1;
               addr_d  = fetch_pc_q;
            end
         end
         StReq: begin
            if (IMemAck) begin
               if (Redirect) begin
                  state_d = StIdle;
                  req_d   = 1'b0;
               end else begin
                  fetch_pc_d = fetch_pc_q + 32'd4;
                  if (count_d != Full) begin
                     addr_d = fetch_pc_q + 32'd4;
                  end else begin
                     state_d = StIdle;
                     req_d   = 1'b0;
                  end
               end
            end else if (Redirect) begin
               // Request cannot be retracted; wait out its ack and discard it.
               state_d = StDrop;
            end
         end
         StDrop: begin
            if (IMemAck) begin
               state_d = StIdle;
               req_d   = 1'b0;
            end
         end
         default: begin
            state_d = StIdle;
            req_d   = 1'b0;
         end
      endcase
      if (Redirect) begin
         fetch_pc_d = RedirectPC & ~32'h0000_0003;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Resetn) begin
         state_q    <= StIdle;
         req_q      <= 1'b0;
         addr_q     <= '0;
         fetch_pc_q <= RESET_PC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         fetch_pc_q <= fetch_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   always_ff @(posedge Clk) begin
      if (push) begin
         pc_mem[wr_ptr_q]   <= addr_q;
         inst_mem[wr_ptr_q] <= IMemData;
      end
   end

   always_comb begin
      Inst      = '0;
      InstPC    = '0;
      InstValid = 1'b0;
      if (head_valid) begin
         Inst      = inst_mem[rd_ptr_q];
         InstPC    = pc_mem[rd_ptr_q];
         InstValid = 1'b1;
      end else if (bypass) begin
         Inst      = IMemData;
         InstPC    = addr_q;
         InstValid = 1'b1;
      end
   end

   assign IMemReq  = req_q;
   assign IMemAddr = addr_q;
   assign Count    = count_q;

endmodule
